// File: rtl/acdma_xbar_pkg.sv
// Shared helpers for the ACDMA crossbar: Walsh chip generator, lane/accumulator
// width functions and the port index type.
package acdma_xbar_pkg;

    typedef int unsigned port_idx_t;

    function automatic int lane_width(input int num_ports);
        return $clog2(num_ports) + 2;
    endfunction

    function automatic int acc_width(input int num_ports, input int code_width);
        return $clog2(num_ports * code_width) + 2;
    endfunction

    // Returns 1 when chip k of Walsh code `code` is -1, 0 when it is +1.
    function automatic logic walsh_chip(input port_idx_t code, input port_idx_t k);
        return ^(code & k);
    endfunction

endpackage

// File: rtl/cdma_rr_arbiter.sv
// Per-destination round-robin arbiter; grants at most one requester on the
// boundary strobe and advances its pointer past the winner.
module cdma_rr_arbiter
    import acdma_xbar_pkg::*;
#(
    parameter int NUM_PORTS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 strobe,
    output logic [NUM_PORTS-1:0] grant
);
    localparam int IW = $clog2(NUM_PORTS);

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] rr_next;
    logic [IW-1:0] idx;
    logic [IW:0]   idx_sum;
    logic          found;

    always_comb begin
        grant   = '0;
        found   = 1'b0;
        rr_next = rr_ptr;
        idx     = '0;
        idx_sum = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            // Circular search starting at rr_ptr; the sum never exceeds 2*NUM_PORTS-2.
            idx_sum = {1'b0, rr_ptr} + (IW+1)'(i);
            if (idx_sum >= (IW+1)'(NUM_PORTS))
                idx_sum = idx_sum - (IW+1)'(NUM_PORTS);
            idx = idx_sum[IW-1:0];
            if (strobe && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                rr_next    = (idx == IW'(NUM_PORTS - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= '0;
        else
            rr_ptr <= rr_next;
    end

endmodule

// File: rtl/acdma_xbar.sv
// ACDMA crossbar: Walsh-spread inputs share one summed channel, outputs despread.
// Optional decode-error checking is enabled with `define CDMA_XBAR_CHECK_EN.
module acdma_xbar
    import acdma_xbar_pkg::*;
#(
    parameter int NUM_PORTS  = 8,
    parameter int DATA_WIDTH = 8,
    parameter int CODE_WIDTH = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_PORTS-1:0]                   in_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]        in_data,
    input  logic [NUM_PORTS*$clog2(NUM_PORTS)-1:0] in_dest,
    output logic [NUM_PORTS-1:0]                   in_ready,
    output logic [NUM_PORTS-1:0]                   out_valid,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]        out_data,
    output logic [NUM_PORTS*$clog2(NUM_PORTS)-1:0] out_src
`ifdef CDMA_XBAR_CHECK_EN
    ,
    output logic [NUM_PORTS-1:0]                   out_err
`endif
);
    localparam int IW = $clog2(NUM_PORTS);
    localparam int KW = $clog2(CODE_WIDTH);
    localparam int LW = lane_width(NUM_PORTS);
    localparam int AW = acc_width(NUM_PORTS, CODE_WIDTH);

    if (NUM_PORTS < 2 || CODE_WIDTH < NUM_PORTS || (CODE_WIDTH & (CODE_WIDTH - 1)) != 0) begin : g_bad_params
        $error("acdma_xbar: NUM_PORTS must be >= 2, CODE_WIDTH a power of two >= NUM_PORTS");
    end

    logic [KW-1:0]        k;
    logic [KW-1:0]        kd;
    logic                 boundary;
    logic [NUM_PORTS-1:0] req  [NUM_PORTS];
    logic [NUM_PORTS-1:0] gnt  [NUM_PORTS];
    logic [NUM_PORTS-1:0] gnt_any;
    logic [IW-1:0]        gnt_src [NUM_PORTS];

    // The channel register delays every chip by one cycle, so decode runs on k-1.
    assign boundary = (k == KW'(CODE_WIDTH - 1));
    assign kd       = k - 1'b1;

    always_comb begin
        for (int d = 0; d < NUM_PORTS; d++)
            for (int p = 0; p < NUM_PORTS; p++)
                req[d][p] = in_valid[p] && (in_dest[p*IW +: IW] == IW'(d));
    end

    for (genvar d = 0; d < NUM_PORTS; d++) begin : g_arb
        cdma_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
            .clk    (clk),
            .rst_n  (rst_n),
            .req    (req[d]),
            .strobe (boundary),
            .grant  (gnt[d])
        );
    end

    always_comb begin
        in_ready = '0;
        for (int d = 0; d < NUM_PORTS; d++) begin
            in_ready   = in_ready | gnt[d];
            gnt_any[d] = |gnt[d];
            gnt_src[d] = '0;
            for (int p = 0; p < NUM_PORTS; p++)
                if (gnt[d][p]) gnt_src[d] = IW'(p);
        end
    end

    logic [NUM_PORTS-1:0]  hold_valid;
    logic [DATA_WIDTH-1:0] hold_data [NUM_PORTS];
    logic [IW-1:0]         hold_dest [NUM_PORTS];
    logic [NUM_PORTS-1:0]  enc_grant;
    logic [NUM_PORTS-1:0]  dec_grant;
    logic [IW-1:0]         enc_src [NUM_PORTS];
    logic [IW-1:0]         dec_src [NUM_PORTS];

    logic [DATA_WIDTH-1:0][LW-1:0] chan;
    logic [DATA_WIDTH-1:0][LW-1:0] chan_next;

    // Bipolar value per lane is +1 exactly when the data bit differs from the chip sign bit.
    always_comb begin
        chan_next = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (hold_valid[p]) begin
                for (int b = 0; b < DATA_WIDTH; b++) begin
                    if (hold_data[p][b] ^ walsh_chip(32'(hold_dest[p]), 32'(k)))
                        chan_next[b] = chan_next[b] + LW'(1);
                    else
                        chan_next[b] = chan_next[b] - LW'(1);
                end
            end
        end
    end

    localparam logic signed [AW-1:0] CW_POS = AW'(CODE_WIDTH);
    localparam logic signed [AW-1:0] CW_NEG = -CW_POS;

    logic signed [AW-1:0]  acc      [NUM_PORTS][DATA_WIDTH];
    logic signed [AW-1:0]  acc_next [NUM_PORTS][DATA_WIDTH];
    logic signed [AW-1:0]  lane_s;
    logic [DATA_WIDTH-1:0] dec_data [NUM_PORTS];
    logic [NUM_PORTS-1:0]  dec_err;

    always_comb begin
        lane_s  = '0;
        dec_err = '0;
        for (int q = 0; q < NUM_PORTS; q++) begin
            dec_data[q] = '0;
            for (int b = 0; b < DATA_WIDTH; b++) begin
                lane_s = AW'($signed(chan[b]));
                if (walsh_chip(port_idx_t'(q), 32'(kd)))
                    lane_s = -lane_s;
                acc_next[q][b] = ((kd == '0) ? '0 : acc[q][b]) + lane_s;
                dec_data[q][b] = (acc_next[q][b] > 0);
                if (acc_next[q][b] != CW_POS && acc_next[q][b] != CW_NEG)
                    dec_err[q] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k          <= '0;
            hold_valid <= '0;
            enc_grant  <= '0;
            dec_grant  <= '0;
            chan       <= '0;
            out_valid  <= '0;
            out_data   <= '0;
            out_src    <= '0;
`ifdef CDMA_XBAR_CHECK_EN
            out_err    <= '0;
`endif
            for (int p = 0; p < NUM_PORTS; p++) begin
                hold_data[p] <= '0;
                hold_dest[p] <= '0;
                enc_src[p]   <= '0;
                dec_src[p]   <= '0;
                for (int b = 0; b < DATA_WIDTH; b++)
                    acc[p][b] <= '0;
            end
        end else begin
            k    <= k + 1'b1;
            chan <= chan_next;
            acc  <= acc_next;
            if (boundary) begin
                hold_valid <= in_ready;
                enc_grant  <= gnt_any;
                dec_grant  <= enc_grant;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (in_ready[p]) begin
                        hold_data[p] <= in_data[p*DATA_WIDTH +: DATA_WIDTH];
                        hold_dest[p] <= in_dest[p*IW +: IW];
                    end
                    enc_src[p] <= gnt_src[p];
                    dec_src[p] <= enc_src[p];
                end
            end
            out_valid <= '0;
            if (kd == KW'(CODE_WIDTH - 1)) begin
                for (int q = 0; q < NUM_PORTS; q++) begin
                    if (dec_grant[q]) begin
                        out_valid[q]                           <= 1'b1;
                        out_data[q*DATA_WIDTH +: DATA_WIDTH]   <= dec_data[q];
                        out_src[q*IW +: IW]                    <= dec_src[q];
`ifdef CDMA_XBAR_CHECK_EN
                        out_err[q]                             <= dec_err[q];
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_acdma_xbar.sv
// Self-checking bench for acdma_xbar: scenario tasks against a transaction-level
// model (round-robin grants, words delivered CODE_WIDTH+2 cycles after acceptance).
module tb_acdma_xbar;
  localparam int NP = 8;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NP-1:0] in_valid, in_ready, out_valid;
  logic [NP*DW-1:0] in_data, out_data;
  logic [NP*IW-1:0] in_dest, out_src;
`ifdef CDMA_XBAR_CHECK_EN
  logic [NP-1:0] out_err;
`endif

  always #5 clk = ~clk;

  acdma_xbar #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .CODE_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_dest(in_dest), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src)
`ifdef CDMA_XBAR_CHECK_EN
    , .out_err(out_err)
`endif
  );

  typedef struct {
    int due;
    int dest;
    logic [DW-1:0] data;
    logic [IW-1:0] src;
    logic err;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int gcyc = 0;
  int mk = 0;
  int rr[NP];
  int mode = 0;
  int force_cyc = -1;
  int first_rdy = -1;
  logic [DW-1:0] hold_data[NP];
  logic [IW-1:0] hold_src[NP];
  logic hold_err[NP];
  logic sv[NP];
  logic [DW-1:0] sd[NP];
  int sdst[NP];
  int gnt3_log[$];
  logic [DW-1:0] d3_log[$];

  always @(posedge clk) gcyc <= gcyc + 1;

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      in_valid[p] = sv[p];
      in_data[p*DW +: DW] = sd[p];
      in_dest[p*IW +: IW] = IW'(sdst[p]);
    end
  endtask

  task automatic model_clear();
    mk = 0;
    exp_q.delete();
    gnt3_log.delete();
    d3_log.delete();
    first_rdy = -1;
    for (int p = 0; p < NP; p++) begin
      rr[p] = 0;
      hold_data[p] = '0;
      hold_src[p] = '0;
      hold_err[p] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    force_cyc = -1;
    for (int p = 0; p < NP; p++) begin
      sv[p] = 1'b0; sd[p] = '0; sdst[p] = 0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_clear();
  endtask

  // Runs n cycles: model grants at boundaries, checks handshakes and outputs every cycle.
  task automatic run_traffic(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      logic [NP-1:0] exp_rdy;
      logic expv;
      int win;
      int idx;
      @(negedge clk);
`ifdef CDMA_XBAR_CHECK_EN
      if (gcyc == force_cyc) release dut.chan;
`endif
      exp_rdy = '0;
      if (mk == CW - 1) begin
        for (int d = 0; d < NP; d++) begin
          win = -1;
          for (int j = 0; j < NP; j++) begin
            idx = (rr[d] + j) % NP;
            if (win < 0 && sv[idx] && sdst[idx] == d) win = idx;
          end
          if (win >= 0) begin
            exp_rdy[win] = 1'b1;
            rr[d] = (win + 1) % NP;
            exp_q.push_back('{gcyc + CW + 2, d, sd[win], IW'(win),
                              (force_cyc >= gcyc + 2 && force_cyc <= gcyc + CW + 1)});
          end
        end
        for (int p = 0; p < NP; p++)
          if (in_ready[p] && sdst[p] == 3) gnt3_log.push_back(p);
      end
      if (|in_ready && first_rdy < 0) first_rdy = gcyc;
      n_checks++;
      if (in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL %s in_ready cyc=%0d got=%b want=%b", name, gcyc, in_ready, exp_rdy);
      end
      for (int q = 0; q < NP; q++) begin
        expv = 1'b0;
        for (int j = 0; j < exp_q.size(); j++) begin
          if (exp_q[j].due == gcyc && exp_q[j].dest == q) begin
            expv = 1'b1;
            hold_data[q] = exp_q[j].data;
            hold_src[q] = exp_q[j].src;
            hold_err[q] = exp_q[j].err;
            exp_q.delete(j);
            break;
          end
        end
        n_checks++;
        if (out_valid[q] !== expv) begin
          n_fail++;
          $display("FAIL %s out_valid[%0d] cyc=%0d got=%b want=%b", name, q, gcyc, out_valid[q], expv);
        end
        n_checks++;
        if (out_data[q*DW +: DW] !== hold_data[q] || out_src[q*IW +: IW] !== hold_src[q]) begin
          n_fail++;
          $display("FAIL %s out_data/src[%0d] cyc=%0d got=%h/%0d want=%h/%0d", name, q, gcyc,
                   out_data[q*DW +: DW], out_src[q*IW +: IW], hold_data[q], hold_src[q]);
        end
`ifdef CDMA_XBAR_CHECK_EN
        n_checks++;
        if (out_err[q] !== hold_err[q]) begin
          n_fail++;
          $display("FAIL %s out_err[%0d] cyc=%0d got=%b want=%b", name, q, gcyc, out_err[q], hold_err[q]);
        end
`endif
      end
      if (out_valid[3]) d3_log.push_back(out_data[3*DW +: DW]);
      @(posedge clk);
      mk = (mk + 1) % CW;
      if (mode == 1) begin
        for (int p = 0; p < NP; p++) begin
          if (exp_rdy[p] || !sv[p]) begin
            sv[p] = ($urandom_range(0, 3) != 0);
            sd[p] = DW'($urandom);
            sdst[p] = $urandom_range(0, NP - 1);
          end
        end
      end
      #1 drive();
`ifdef CDMA_XBAR_CHECK_EN
      if (gcyc == force_cyc) force dut.chan = '0;
`endif
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int p = 0; p < NP; p++) begin
      sv[p] = 1'b1; sd[p] = DW'(p); sdst[p] = p;
    end
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (in_ready !== '0 || out_valid !== '0 || out_data !== '0 || out_src !== '0) begin
      n_fail++;
      $display("FAIL reset_values got rdy=%b v=%b d=%h s=%h want all zero", in_ready, out_valid, out_data, out_src);
    end
    do_reset();
    mode = 0;
    run_traffic("reset_idle", 12);
  endtask

  task automatic test_identity();
    do_reset();
    mode = 0;
    for (int p = 0; p < NP; p++) begin
      sv[p] = 1'b1; sd[p] = 8'hA0 + DW'(p); sdst[p] = p;
    end
    drive();
    run_traffic("identity", 40);
  endtask

  task automatic test_conflict();
    int want_g[4];
    logic [DW-1:0] want_d[4];
    want_g = '{2, 5, 7, 2};
    want_d = '{8'h22, 8'h55, 8'h77, 8'h22};
    do_reset();
    mode = 0;
    sv[2] = 1'b1; sd[2] = 8'h22; sdst[2] = 3;
    sv[5] = 1'b1; sd[5] = 8'h55; sdst[5] = 3;
    sv[7] = 1'b1; sd[7] = 8'h77; sdst[7] = 3;
    drive();
    run_traffic("conflict", 44);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= gnt3_log.size() || gnt3_log[i] != want_g[i]) begin
        n_fail++;
        $display("FAIL conflict_grant_order #%0d got=%0d want=%0d", i,
                 (i < gnt3_log.size()) ? gnt3_log[i] : -1, want_g[i]);
      end
      n_checks++;
      if (i >= d3_log.size() || d3_log[i] !== want_d[i]) begin
        n_fail++;
        $display("FAIL conflict_data_order #%0d got=%h want=%h", i,
                 (i < d3_log.size()) ? d3_log[i] : 8'h00, want_d[i]);
      end
    end
  endtask

  task automatic test_partial();
    do_reset();
    mode = 0;
    sv[0] = 1'b1; sd[0] = 8'hFF; sdst[0] = 6;
    drive();
    run_traffic("partial", 30);
  endtask

  task automatic test_permutation();
    logic [3:0] p4;
    do_reset();
    mode = 0;
    for (int p = 0; p < NP; p++) begin
      p4 = 4'(p);
      sv[p] = 1'b1; sd[p] = {p4, ~p4}; sdst[p] = NP - 1 - p;
    end
    drive();
    run_traffic("permutation", 30);
  endtask

  task automatic test_reset_mid();
    int r0;
    do_reset();
    mode = 0;
    for (int p = 0; p < NP; p++) begin
      sv[p] = 1'b1; sd[p] = 8'h30 + DW'(p); sdst[p] = p;
    end
    drive();
    run_traffic("reset_mid_pre", 28);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== '0 || out_valid !== '0 || out_data !== '0 || out_src !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_clear got rdy=%b v=%b d=%h s=%h want all zero", in_ready, out_valid, out_data, out_src);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_clear();
    r0 = gcyc;
    run_traffic("reset_mid_post", 24);
    n_checks++;
    if (first_rdy != r0 + 7) begin
      n_fail++;
      $display("FAIL reset_mid_first_grant got=%0d want=%0d", first_rdy - r0, 7);
    end
  endtask

  task automatic test_random();
    do_reset();
    mode = 1;
    for (int p = 0; p < NP; p++) begin
      sv[p] = ($urandom_range(0, 1) != 0);
      sd[p] = DW'($urandom);
      sdst[p] = $urandom_range(0, NP - 1);
    end
    drive();
    run_traffic("random", 240);
    mode = 0;
  endtask

`ifdef CDMA_XBAR_CHECK_EN
  task automatic test_check_err();
    do_reset();
    mode = 0;
    sv[1] = 1'b1; sd[1] = 8'h3C; sdst[1] = 6;
    drive();
    force_cyc = gcyc + 9;
    run_traffic("check_err", 30);
    force_cyc = -1;
  endtask
`endif

  initial begin
    for (int p = 0; p < NP; p++) begin
      sv[p] = 1'b0; sd[p] = '0; sdst[p] = 0;
    end
    drive();
    test_reset();
    test_identity();
    test_conflict();
    test_partial();
    test_permutation();
    test_reset_mid();
    test_random();
`ifdef CDMA_XBAR_CHECK_EN
    test_check_err();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
